r_triadic_issue_ctrl: RTL and testbench

//  Sequencer for the R-type triadic datapath (32x32 register file + ALU).

---
 rtl/r_triadic_issue_ctrl.sv | 136 +++++++++++++
 tb/tb_r_triadic_issue_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/r_triadic_issue_ctrl.sv
// Issue sequencer for the R-type triadic datapath: gathers a 32-bit instruction from byte
// beats, drives register-file/ALU fields, pulses write-back and returns the result in halves.
module r_triadic_issue_ctrl #(
    parameter int EXEC_CYCLES = 1,
    parameter int LO_FIRST    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        byte_ready,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [5:0]  alu_ctrl,
    output logic        rf_we,
    input  logic [31:0] alu_y,
    output logic        out_valid,
    output logic [15:0] out_half,
    input  logic        out_ready,
    output logic        busy,
    output logic        err_opcode,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        S_LOAD,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_OUT0,
        S_OUT1
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  beat_cnt_q, beat_cnt_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] result_q, result_d;
    logic [3:0]  exec_cnt_q, exec_cnt_d;
    logic [15:0] out_half_q, out_half_d;
    logic        err_q, err_d;
    logic [15:0] retired_q, retired_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_LOAD;
            beat_cnt_q <= '0;
            ir_q       <= '0;
            result_q   <= '0;
            exec_cnt_q <= '0;
            out_half_q <= '0;
            err_q      <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            ir_q       <= ir_d;
            result_q   <= result_d;
            exec_cnt_q <= exec_cnt_d;
            out_half_q <= out_half_d;
            err_q      <= err_d;
            retired_q  <= retired_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        ir_d       = ir_q;
        result_d   = result_q;
        exec_cnt_d = exec_cnt_q;
        out_half_d = out_half_q;
        err_d      = err_q;
        retired_d  = retired_q;

        unique case (state_q)
            S_LOAD: begin
                if (byte_valid) begin
                    ir_d[{beat_cnt_q, 3'b000} +: 8] = byte_in;
                    // Two-bit counter wraps back to 0 on the fourth beat.
                    beat_cnt_d = beat_cnt_q + 2'd1;
                    if (beat_cnt_q == 2'd3) begin
                        state_d = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                if (ir_q[31:26] != 6'd0) begin
                    err_d   = 1'b1;
                    state_d = S_LOAD;
                end else begin
                    exec_cnt_d = '0;
                    state_d    = S_EXEC;
                end
            end
            S_EXEC: begin
                exec_cnt_d = exec_cnt_q + 4'd1;
                if (exec_cnt_q == 4'(EXEC_CYCLES - 1)) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                result_d   = alu_y;
                retired_d  = retired_q + 16'd1;
                // The first half is staged here so it is valid on the first OUT0 cycle.
                out_half_d = (LO_FIRST != 0) ? alu_y[15:0] : alu_y[31:16];
                state_d    = S_OUT0;
            end
            S_OUT0: begin
                if (out_ready) begin
                    out_half_d = (LO_FIRST != 0) ? result_q[31:16] : result_q[15:0];
                    state_d    = S_OUT1;
                end
            end
            S_OUT1: begin
                if (out_ready) begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    assign byte_ready = (state_q == S_LOAD);
    assign busy       = (state_q != S_LOAD);
    assign rf_we      = (state_q == S_WB);
    assign out_valid  = (state_q == S_OUT0) || (state_q == S_OUT1);
    assign out_half   = out_half_q;
    assign err_opcode = err_q;
    assign retired    = retired_q;
    assign rs1        = ir_q[25:21];
    assign rs2        = ir_q[20:16];
    assign rd         = ir_q[15:11];
    assign alu_ctrl   = ir_q[5:0];

endmodule

// File: tb/tb_r_triadic_issue_ctrl.sv
// Randomized self-checking bench for r_triadic_issue_ctrl against an instruction-level model.
module tb_r_triadic_issue_ctrl;

    localparam int EXEC_CYCLES = 3;
    localparam int LO_FIRST    = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_in = '0;
    logic        byte_ready;
    logic [4:0]  rs1, rs2, rd;
    logic [5:0]  alu_ctrl;
    logic        rf_we;
    logic [31:0] alu_y = '0;
    logic        out_valid;
    logic [15:0] out_half;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        err_opcode;
    logic [15:0] retired;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   we_cnt = 0;
    int   exp_retired = 0;
    logic exp_err = 1'b0;

    r_triadic_issue_ctrl #(
        .EXEC_CYCLES(EXEC_CYCLES),
        .LO_FIRST   (LO_FIRST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .byte_valid(byte_valid),
        .byte_in   (byte_in),
        .byte_ready(byte_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .alu_ctrl  (alu_ctrl),
        .rf_we     (rf_we),
        .alu_y     (alu_y),
        .out_valid (out_valid),
        .out_half  (out_half),
        .out_ready (out_ready),
        .busy      (busy),
        .err_opcode(err_opcode),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rf_we === 1'b1) we_cnt <= we_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feeds one instruction and follows it through write-back and both output halves.
    task automatic run_instr(input logic [31:0] ir, input logic [31:0] aval,
                             input int gap_max, input int stall_fixed);
        int          we0, t_acc, n, stalls;
        logic [15:0] h[2];
        we0 = we_cnt;
        t_acc = 0;
        for (int k = 0; k < 4; k++) begin
            n = $urandom_range(0, gap_max);
            byte_valid = 1'b0;
            repeat (n) tick();
            byte_valid = 1'b1;
            byte_in    = ir[8*k +: 8];
            checks++;
            if (byte_ready !== 1'b1) begin
                failures++;
                $display("FAIL load_ready beat=%0d got=%b exp=1", k, byte_ready);
            end
            t_acc = cyc;
            tick();
        end
        // Junk bytes are offered while busy; they must never reach the IR.
        byte_valid = (ir[31:26] == 6'd0);
        byte_in    = 8'($urandom);
        alu_y      = aval;
        checks++;
        if ({rs1, rs2, rd, alu_ctrl} !== {ir[25:21], ir[20:16], ir[15:11], ir[5:0]}) begin
            failures++;
            $display("FAIL decode_fields got=%h/%h/%h/%h ir=%h", rs1, rs2, rd, alu_ctrl, ir);
        end
        checks++;
        if ({busy, byte_ready, out_valid} !== 3'b100) begin
            failures++;
            $display("FAIL decode_flags got=%b exp=100", {busy, byte_ready, out_valid});
        end
        if (ir[31:26] != 6'd0) begin
            exp_err = 1'b1;
            tick();
            tick();
            checks++;
            if ({byte_ready, busy, err_opcode, retired, 32'(we_cnt)} !==
                {1'b1, 1'b0, 1'b1, 16'(exp_retired), 32'(we0)}) begin
                failures++;
                $display("FAIL bad_opcode got rdy=%b busy=%b err=%b ret=%0d we=%0d exp 1 0 1 %0d %0d",
                         byte_ready, busy, err_opcode, retired, we_cnt, exp_retired, we0);
            end
            return;
        end
        n = 0;
        while (rf_we !== 1'b1 && n < 40) begin
            checks++;
            if ({byte_ready, out_valid} !== 2'b00) begin
                failures++;
                $display("FAIL exec_flags got=%b exp=00", {byte_ready, out_valid});
            end
            tick();
            n++;
        end
        byte_valid = 1'b0;
        checks++;
        if (rf_we !== 1'b1) begin
            failures++;
            $display("FAIL wb_timeout rf_we=%b exp=1", rf_we);
            return;
        end
        checks++;
        if (cyc !== t_acc + 2 + EXEC_CYCLES) begin
            failures++;
            $display("FAIL wb_latency got=%0d exp=%0d", cyc - t_acc, 2 + EXEC_CYCLES);
        end
        exp_retired = (exp_retired + 1) & 16'hFFFF;
        tick();
        checks++;
        if ({rf_we, retired, 32'(we_cnt)} !== {1'b0, 16'(exp_retired), 32'(we0 + 1)}) begin
            failures++;
            $display("FAIL wb_pulse got we=%b ret=%0d cnt=%0d exp 0 %0d %0d",
                     rf_we, retired, we_cnt, exp_retired, we0 + 1);
        end
        h[0] = (LO_FIRST != 0) ? aval[15:0] : aval[31:16];
        h[1] = (LO_FIRST != 0) ? aval[31:16] : aval[15:0];
        for (int i = 0; i < 2; i++) begin
            stalls = (stall_fixed >= 0) ? ((i == 0) ? stall_fixed : 0) : $urandom_range(0, 3);
            for (int s = 0; s <= stalls; s++) begin
                out_ready = (s == stalls);
                checks++;
                if ({out_valid, out_half, byte_ready, busy} !== {1'b1, h[i], 1'b0, 1'b1}) begin
                    failures++;
                    $display("FAIL out_half%0d got v=%b d=%h rdy=%b busy=%b exp 1 %h 0 1",
                             i, out_valid, out_half, byte_ready, busy, h[i]);
                end
                tick();
            end
        end
        out_ready = 1'b0;
        checks++;
        if ({out_valid, out_half, byte_ready, busy, 32'(we_cnt)} !==
            {1'b0, h[1], 1'b1, 1'b0, 32'(we0 + 1)}) begin
            failures++;
            $display("FAIL out_done got v=%b d=%h rdy=%b busy=%b we=%0d exp 0 %h 1 0 %0d",
                     out_valid, out_half, byte_ready, busy, we_cnt, h[1], we0 + 1);
        end
    endtask

    task automatic check_reset_state(input string tag);
        checks++;
        if ({byte_ready, rf_we, out_valid, busy, err_opcode, out_half, retired,
             rs1, rs2, rd, alu_ctrl} !== {5'b10000, 16'h0, 16'h0, 21'h0}) begin
            failures++;
            $display("FAIL %s got rdy=%b we=%b v=%b busy=%b err=%b d=%h ret=%h f=%h/%h/%h/%h exp 1 0 0 0 0 0 0 0",
                     tag, byte_ready, rf_we, out_valid, busy, err_opcode, out_half, retired,
                     rs1, rs2, rd, alu_ctrl);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_retired = 0;
        exp_err = 1'b0;
        check_reset_state("reset_state");
    endtask

    task automatic test_decode();
        run_instr(32'h00431820, 32'h0000_1234, 0, 0);
        checks++;
        if ({rs1, rs2, rd, alu_ctrl, retired} !== {5'd2, 5'd3, 5'd3, 6'h20, 16'd1}) begin
            failures++;
            $display("FAIL decode_example got %0d %0d %0d %h ret=%0d exp 2 3 3 20 1",
                     rs1, rs2, rd, alu_ctrl, retired);
        end
    endtask

    task automatic test_halves();
        run_instr(32'h00A5_2822, 32'hDEADBEEF, 0, 0);
    endtask

    task automatic test_stall();
        run_instr(32'h03E0_F825, 32'hDEADBEEF, 2, 5);
    endtask

    task automatic test_bad_opcode();
        run_instr(32'h0443_1820, 32'hCAFEF00D, 1, 0);
        checks++;
        if (err_opcode !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky got=%b exp=1", err_opcode);
        end
    endtask

    task automatic test_reset_midway();
        int n;
        byte_valid = 1'b1;
        byte_in = 8'hFF;
        tick();
        byte_in = 8'hEE;
        tick();
        byte_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_retired = 0;
        exp_err = 1'b0;
        check_reset_state("reset_partial");
        run_instr(32'h0062_2024, 32'h0BAD_F00D, 0, 0);
        for (int k = 0; k < 4; k++) begin
            byte_valid = 1'b1;
            byte_in = (k == 3) ? 8'h00 : 8'($urandom);
            tick();
        end
        byte_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL out_timeout out_valid=%b exp=1", out_valid);
        end
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_retired = 0;
        check_reset_state("reset_output");
    endtask

    task automatic test_random();
        logic [31:0] ir;
        for (int i = 0; i < 40; i++) begin
            ir = $urandom;
            if ($urandom_range(0, 3) != 0) ir[31:26] = 6'd0;
            run_instr(ir, $urandom, 2, -1);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ir;
        for (int i = 0; i < 6; i++) begin
            ir = $urandom & 32'h03FF_FFFF;
            run_instr(ir, $urandom, 0, 0);
        end
        checks++;
        if ({err_opcode, retired} !== {exp_err, 16'(exp_retired)}) begin
            failures++;
            $display("FAIL final_state got err=%b ret=%0d exp %b %0d",
                     err_opcode, retired, exp_err, exp_retired);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_halves();
        test_stall();
        test_bad_opcode();
        test_reset_midway();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
